// File: rtl/multicycle_control.sv
// Multi-cycle RV32 main control: sequences FETCH/DECODE/EXEC/MEM/WB with
// imem/dmem handshakes, memory timeout trap and a retired-instruction counter.
module multicycle_control #(
   parameter int unsigned INST_WIDTH     = 32,
   parameter int unsigned OPCODE_WIDTH   = 7,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INST_WIDTH-1:0] inst,
   input  logic                  imem_ready,
   input  logic                  dmem_ready,
   input  logic                  trap_clr,
   output logic                  imem_req,
   output logic                  dmem_req,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  PCWriteCond,
   output logic                  ALUSrc,
   output logic                  MemtoReg,
   output logic                  RegWrite,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  Branch,
   output logic [1:0]            ALUOp,
   output logic                  trap,
   output logic                  trap_cause,
   output logic [CNT_WIDTH-1:0]  retired,
   output logic [2:0]            state
);

   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [OPCODE_WIDTH-1:0] OP_R      = OPCODE_WIDTH'(7'b0110011);
   localparam logic [OPCODE_WIDTH-1:0] OP_I      = OPCODE_WIDTH'(7'b0010011);
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_R      = 3'd0,
      C_I      = 3'd1,
      C_LOAD   = 3'd2,
      C_STORE  = 3'd3,
      C_BRANCH = 3'd4,
      C_JAL    = 3'd5
   } class_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   class_t                  r_class;
   class_t                  w_class_nxt;
   logic                    r_trap_cause;
   logic                    w_cause_nxt;
   logic [TCNT_W-1:0]       r_tcnt;
   logic                    w_tcnt_inc;
   logic                    w_retire;
   logic [CNT_WIDTH-1:0]    r_retired;
   logic [OPCODE_WIDTH-1:0] w_opcode;
   logic                    w_unused_inst;

   assign w_opcode      = inst[OPCODE_WIDTH-1:0];
   assign w_unused_inst = ^inst[INST_WIDTH-1:OPCODE_WIDTH];
   assign retired       = r_retired;
   assign state         = r_state;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and Moore/handshake output decode
   always_comb begin
      w_state_nxt = r_state;
      w_class_nxt = r_class;
      w_cause_nxt = r_trap_cause;
      w_tcnt_inc  = 1'b0;
      w_retire    = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      ALUSrc      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Branch      = 1'b0;
      ALUOp       = 2'b00;
      trap        = 1'b0;
      trap_cause  = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               IRWrite     = 1'b1;
               PCWrite     = 1'b1;
               w_state_nxt = S_DECODE;
            end else if (r_tcnt == TCNT_LAST) begin
               w_cause_nxt = 1'b1;
               w_state_nxt = S_TRAP;
            end else begin
               w_tcnt_inc = 1'b1;
            end
         end
         S_DECODE: begin
            w_state_nxt = S_EXEC;
            case (w_opcode)
               OP_R:      w_class_nxt = C_R;
               OP_I:      w_class_nxt = C_I;
               OP_LOAD:   w_class_nxt = C_LOAD;
               OP_STORE:  w_class_nxt = C_STORE;
               OP_BRANCH: w_class_nxt = C_BRANCH;
               OP_JAL:    w_class_nxt = C_JAL;
               default: begin
                  w_cause_nxt = 1'b0;
                  w_state_nxt = S_TRAP;
               end
            endcase
         end
         S_EXEC: begin
            case (r_class)
               C_R: begin
                  ALUOp       = 2'b10;
                  w_state_nxt = S_WB;
               end
               C_I: begin
                  ALUSrc      = 1'b1;
                  ALUOp       = 2'b10;
                  w_state_nxt = S_WB;
               end
               C_LOAD, C_STORE: begin
                  ALUSrc      = 1'b1;
                  w_state_nxt = S_MEM;
               end
               C_BRANCH: begin
                  Branch      = 1'b1;
                  ALUOp       = 2'b01;
                  PCWriteCond = 1'b1;
                  w_retire    = 1'b1;
                  w_state_nxt = S_FETCH;
               end
               default: begin
                  Branch      = 1'b1;
                  PCWrite     = 1'b1;
                  w_retire    = 1'b1;
                  w_state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            ALUSrc   = 1'b1;
            MemRead  = (r_class == C_LOAD);
            MemWrite = (r_class == C_STORE);
            if (dmem_ready) begin
               if (r_class == C_LOAD) begin
                  w_state_nxt = S_WB;
               end else begin
                  w_retire    = 1'b1;
                  w_state_nxt = S_FETCH;
               end
            end else if (r_tcnt == TCNT_LAST) begin
               w_cause_nxt = 1'b1;
               w_state_nxt = S_TRAP;
            end else begin
               w_tcnt_inc = 1'b1;
            end
         end
         S_WB: begin
            RegWrite    = 1'b1;
            MemtoReg    = (r_class == C_LOAD);
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
         end
         S_TRAP: begin
            trap       = 1'b1;
            trap_cause = r_trap_cause;
            if (trap_clr) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Class latch, trap cause, timeout counter (cleared on any state change), retire count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_class      <= C_R;
         r_trap_cause <= 1'b0;
         r_tcnt       <= '0;
         r_retired    <= '0;
      end else begin
         r_class      <= w_class_nxt;
         r_trap_cause <= w_cause_nxt;
         if (w_state_nxt != r_state) r_tcnt <= '0;
         else if (w_tcnt_inc)        r_tcnt <= r_tcnt + TCNT_W'(1);
         if (w_retire) r_retired <= r_retired + CNT_WIDTH'(1);
      end
   end

endmodule
